// File: rtl/axi4_lite_mem_slave_pkg.sv
// axi4_lite_mem_slave_pkg: shared bus widths, FSM state types and response codes for the AXI4-Lite memory slave.
package axi4_lite_Defs;
    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi4_lite_mem_slave_mem_array.sv
// axi4_lite_mem_array: word storage cleared by reset, one synchronous write port and one registered read port.
module axi4_lite_mem_array
    import axi4_lite_Defs::*;
#(
    parameter int DATA_WIDTH = Data_Width,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic                         i_re,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]        o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    // Non-blocking update gives read-before-write when both ports hit the same word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            if (i_re) r_rdata <= r_mem[i_raddr];
        end
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi4_lite_mem_slave.sv
// axi4_lite_mem_slave: AXI4-Lite slave exposing MEM_DEPTH words with independent read and write FSMs.
// Define AXI_SLV_ERR_EN to add RRESP/BRESP and decode errors for out-of-range addresses.
module axi4_lite_mem_slave
    import axi4_lite_Defs::*;
#(
    parameter int ADDR_WIDTH = Addr_Width,
    parameter int DATA_WIDTH = Data_Width,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    input  logic                  RREADY,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
`ifdef AXI_SLV_ERR_EN
    output logic [1:0]            RRESP,
    output logic [1:0]            BRESP,
`endif
    output logic                  BVALID,
    input  logic                  BREADY
);
    localparam int IW = $clog2(MEM_DEPTH);
    rd_state_t             r_rstate;
    wr_state_t             r_wstate;
    logic                  r_arready, r_rvalid, r_awready, r_wready, r_bvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_ar_hs, w_aw_hs, w_w_hs, w_commit, w_werr, w_unused;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdat, w_rdata;
    assign w_ar_hs  = ARVALID & r_arready;
    assign w_aw_hs  = AWVALID & r_awready;
    assign w_w_hs   = WVALID & r_wready;
    assign w_waddr  = w_aw_hs ? AWADDR : r_awaddr;
    assign w_wdat   = w_w_hs ? WDATA : r_wdata;
    // Commit on the edge where the second of AW/W is captured (or both together).
    assign w_commit = (r_wstate == W_IDLE) & (w_aw_hs | ~r_awready) & (w_w_hs | ~r_wready);
    assign w_unused = ^{ARADDR[1:0], AWADDR[1:0], ARADDR[ADDR_WIDTH-1:IW+2], AWADDR[ADDR_WIDTH-1:IW+2]};
`ifdef AXI_SLV_ERR_EN
    logic       w_rerr;
    logic [1:0] r_rresp, r_bresp;
    assign w_rerr = |ARADDR[ADDR_WIDTH-1:IW+2];
    assign w_werr = |w_waddr[ADDR_WIDTH-1:IW+2];
    assign RRESP  = r_rresp;
    assign BRESP  = r_bresp;
    assign RDATA  = (r_rresp == RESP_DECERR) ? '0 : w_rdata;
`else
    assign w_werr = 1'b0;
    assign RDATA  = w_rdata;
`endif
    axi4_lite_mem_array #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
        .i_clk(ACLK),
        .i_rst(ARESET),
        .i_we(w_commit & ~w_werr),
        .i_waddr(w_waddr[IW+1:2]),
        .i_wdata(w_wdat),
        .i_re(w_ar_hs),
        .i_raddr(ARADDR[IW+1:2]),
        .o_rdata(w_rdata)
    );
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
`ifdef AXI_SLV_ERR_EN
            r_rresp   <= RESP_OKAY;
`endif
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rstate  <= R_DATA;
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
`ifdef AXI_SLV_ERR_EN
                r_rresp   <= w_rerr ? RESP_DECERR : RESP_OKAY;
`endif
            end
        end else if (RREADY) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
`ifdef AXI_SLV_ERR_EN
            r_bresp   <= RESP_OKAY;
`endif
        end else if (r_wstate == W_IDLE) begin
            if (w_aw_hs) begin
                r_awaddr  <= AWADDR;
                r_awready <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata  <= WDATA;
                r_wready <= 1'b0;
            end
            if (w_commit) begin
                r_wstate <= W_RESP;
                r_bvalid <= 1'b1;
`ifdef AXI_SLV_ERR_EN
                r_bresp  <= w_werr ? RESP_DECERR : RESP_OKAY;
`endif
            end
        end else if (BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
        end
    end
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// tb_axi4_lite_mem_slave: directed checks of reset, writes, reads, backpressure, collision and wrap/decode error.
module tb_axi4_lite_mem_slave;
    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic [31:0] ARADDR = '0, AWADDR = '0, WDATA = '0, RDATA;
    logic        ARVALID = 1'b0, RREADY = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
    logic        ARREADY, RVALID, AWREADY, WREADY, BVALID;
`ifdef AXI_SLV_ERR_EN
    logic [1:0]  RRESP, BRESP;
`endif
    logic [31:0] rd_val;
    logic [1:0]  rd_resp, wr_resp;
    int          n_tot = 0, n_bad = 0;

    axi4_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
`ifdef AXI_SLV_ERR_EN
        .RRESP(RRESP), .BRESP(BRESP),
`endif
        .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 8 && !BVALID; i++) @(negedge ACLK);
        chk("wr_bvalid", {31'd0, BVALID}, 32'd1);
`ifdef AXI_SLV_ERR_EN
        wr_resp = BRESP;
`else
        wr_resp = 2'b00;
`endif
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i < 8 && !RVALID; i++) @(negedge ACLK);
        chk("rd_rvalid", {31'd0, RVALID}, 32'd1);
        d = RDATA;
`ifdef AXI_SLV_ERR_EN
        r = RRESP;
`else
        r = 2'b00;
`endif
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    initial begin
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", {31'd0, ARREADY}, 32'd1);
        chk("rst_awready", {31'd0, AWREADY}, 32'd1);
        chk("rst_wready", {31'd0, WREADY}, 32'd1);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        // Same-cycle AW+W, then hold the response for three cycles.
        AWADDR = 32'h08; WDATA = 32'hDEADBEEF; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_same_bvalid", {31'd0, BVALID}, 32'd1);
        chk("wr_same_awready", {31'd0, AWREADY}, 32'd0);
        chk("wr_same_wready", {31'd0, WREADY}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("wr_bvalid_hold", {31'd0, BVALID}, 32'd1);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("wr_bvalid_drop", {31'd0, BVALID}, 32'd0);
        chk("wr_awready_back", {31'd0, AWREADY}, 32'd1);
        // Read 0x08 with five cycles of RREADY backpressure.
        ARADDR = 32'h08; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rd08_rvalid", {31'd0, RVALID}, 32'd1);
        chk("rd08_rdata", RDATA, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("bp_rvalid", {31'd0, RVALID}, 32'd1);
            chk("bp_rdata", RDATA, 32'hDEADBEEF);
            chk("bp_arready", {31'd0, ARREADY}, 32'd0);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        chk("bp_rvalid_drop", {31'd0, RVALID}, 32'd0);
        chk("bp_arready_back", {31'd0, ARREADY}, 32'd1);
        // Split write: data at cycle 0, address at cycle 3.
        WDATA = 32'h12345678; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        chk("split_wready", {31'd0, WREADY}, 32'd0);
        chk("split_awready", {31'd0, AWREADY}, 32'd1);
        chk("split_bvalid_c1", {31'd0, BVALID}, 32'd0);
        @(negedge ACLK);
        chk("split_bvalid_c2", {31'd0, BVALID}, 32'd0);
        chk("split_wready_c2", {31'd0, WREADY}, 32'd0);
        @(negedge ACLK);
        chk("split_bvalid_c3", {31'd0, BVALID}, 32'd0);
        AWADDR = 32'h04; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("split_bvalid_c4", {31'd0, BVALID}, 32'd1);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        rd(32'h04, rd_val, rd_resp);
        chk("split_rd04", rd_val, 32'h12345678);
        rd(32'h08, rd_val, rd_resp);
        chk("rd08_intact", rd_val, 32'hDEADBEEF);
        chk("rd08_resp", {30'd0, rd_resp}, 32'd0);
        // Write commit and AR to the same word on one edge returns the old word.
        wr(32'h0C, 32'h11111111);
        chk("wr0c_resp", {30'd0, wr_resp}, 32'd0);
        AWADDR = 32'h0C; WDATA = 32'hA5A5A5A5; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h0C; ARVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("coll_rvalid", {31'd0, RVALID}, 32'd1);
        chk("coll_bvalid", {31'd0, BVALID}, 32'd1);
        chk("coll_rdata_old", RDATA, 32'h11111111);
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        rd(32'h0C, rd_val, rd_resp);
        chk("coll_rdata_new", rd_val, 32'hA5A5A5A5);
        // Address 0x40 is one past the top of a 16-word memory.
        wr(32'h40, 32'hCAFEF00D);
`ifdef AXI_SLV_ERR_EN
        chk("err_bresp", {30'd0, wr_resp}, 32'd3);
        rd(32'h40, rd_val, rd_resp);
        chk("err_rresp", {30'd0, rd_resp}, 32'd3);
        chk("err_rdata", rd_val, 32'd0);
        rd(32'h00, rd_val, rd_resp);
        chk("err_rd00", rd_val, 32'd0);
        chk("err_rd00_resp", {30'd0, rd_resp}, 32'd0);
`else
        chk("wrap_bresp", {30'd0, wr_resp}, 32'd0);
        rd(32'h00, rd_val, rd_resp);
        chk("wrap_rd00", rd_val, 32'hCAFEF00D);
`endif
        // Asynchronous reset while a read response is pending.
        ARADDR = 32'h08; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("mid_rvalid_pre", {31'd0, RVALID}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        chk("mid_rvalid", {31'd0, RVALID}, 32'd0);
        chk("mid_arready", {31'd0, ARREADY}, 32'd1);
        chk("mid_rdata", RDATA, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        rd(32'h00, rd_val, rd_resp);
        chk("post_rst_rd00", rd_val, 32'd0);
        rd(32'h08, rd_val, rd_resp);
        chk("post_rst_rd08", rd_val, 32'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
